// File: rtl/phy_tx_sched.sv
// Four-lane round-robin byte scheduler feeding the phy_tx serializer.
// Carves clk_32f into 8-cycle slots and emits one byte (lane data or IDLE filler) per slot.
module phy_tx_sched #(
    parameter int SYNC_SLOTS = 4
) (
    input  logic       clk_32f,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] IDLE,
    input  logic [7:0] in0,
    input  logic [7:0] in1,
    input  logic [7:0] in2,
    input  logic [7:0] in3,
    input  logic       valid_in0,
    input  logic       valid_in1,
    input  logic       valid_in2,
    input  logic       valid_in3,
    output logic       ack_out0,
    output logic       ack_out1,
    output logic       ack_out2,
    output logic       ack_out3,
    output logic [7:0] data_out,
    output logic       byte_strobe,
    output logic [1:0] lane_id,
    output logic       data_is_idle,
    output logic [2:0] bit_phase,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        ST_OFF    = 2'b00,
        ST_SYNC   = 2'b01,
        ST_ACTIVE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  sync_cnt_q, sync_cnt_d;
    logic [2:0]  phase_q;
    logic [1:0]  ptr_q;
    logic [3:0]  ack_q;
    logic [3:0]  valid_vec;
    logic        boundary;
    logic        grant;
    logic [1:0]  grant_lane;
    logic [1:0]  cand;
    logic [7:0]  grant_data;
    logic        take;

    assign boundary  = (phase_q == 3'd7);
    assign valid_vec = {valid_in3, valid_in2, valid_in1, valid_in0};
    assign bit_phase = phase_q;
    assign ack_out0  = ack_q[0];
    assign ack_out1  = ack_q[1];
    assign ack_out2  = ack_q[2];
    assign ack_out3  = ack_q[3];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_OFF;
            sync_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            sync_cnt_q <= sync_cnt_d;
        end
    end

    // Transitions are only evaluated at the slot boundary; en is sampled there.
    // NOTE: defaults at the top of every always_comb keep it free of latches.
    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        if (boundary) begin
            unique case (state_q)
                ST_OFF: begin
                    if (en) begin
                        state_d    = ST_SYNC;
                        sync_cnt_d = 4'd0;
                    end
                end
                ST_SYNC: begin
                    if (!en) begin
                        state_d = ST_OFF;
                    end else begin
                        sync_cnt_d = sync_cnt_q + 4'd1;
                        if (sync_cnt_q == 4'(SYNC_SLOTS - 1)) begin
                            state_d = ST_ACTIVE;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (!en) begin
                        state_d = ST_OFF;
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    always_comb begin
        take      = boundary && (state_q == ST_ACTIVE) && en && grant;
        state_out = state_q;
    end

    // Round-robin search starting one past the last granted lane.
    always_comb begin
        grant      = 1'b0;
        grant_lane = ptr_q;
        cand       = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!grant && valid_vec[cand]) begin
                grant      = 1'b1;
                grant_lane = cand;
            end
        end
    end

    always_comb begin
        grant_data = in0;
        unique case (grant_lane)
            2'd0: grant_data = in0;
            2'd1: grant_data = in1;
            2'd2: grant_data = in2;
            2'd3: grant_data = in3;
            default: grant_data = in0;
        endcase
    end

    // Slot datapath: the ack lands in the bit_phase==0 cycle alongside the strobe.
    always_ff @(posedge clk_32f or negedge rst) begin
        if (!rst) begin
            phase_q      <= 3'd0;
            data_out     <= 8'h00;
            data_is_idle <= 1'b1;
            lane_id      <= 2'd0;
            byte_strobe  <= 1'b0;
            ack_q        <= 4'b0000;
            ptr_q        <= 2'd3;
        end else begin
            phase_q     <= phase_q + 3'd1;
            byte_strobe <= boundary;
            ack_q       <= take ? (4'b0001 << grant_lane) : 4'b0000;
            if (boundary) begin
                data_out     <= take ? grant_data : IDLE;
                lane_id      <= take ? grant_lane : 2'd0;
                data_is_idle <= !take;
            end
            if (take) begin
                ptr_q <= grant_lane;
            end
        end
    end

endmodule
